// File: rtl/phase_xcorr_engine.sv
// phase_xcorr_engine
// Captures N voltage/current sample pairs, then walks every circular lag k and
// accumulates R[k] = sum_i signal_1[i]*signal_2[(i+k) mod N], one product per
// cycle. The lag with the largest R[k] becomes peak_lag, and its signed
// half-record equivalent is scaled into phase_diff.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for start; outputs hold the last result
// CAPTURE | storing sample pairs at cnt on every sample_valid cycle
// CORR    | issuing (k,i) products and draining the read/multiply pipeline
// RESULT  | single cycle with done=1; the outputs carry the new result

module phase_xcorr_engine #(
  parameter int DATA_W  = 12,
  parameter int LOG2_N  = 10,
  parameter int PHASE_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            signal_1,
  input  logic [DATA_W-1:0]            signal_2,
  output logic                         busy,
  output logic                         done,
  output logic [LOG2_N-1:0]            peak_lag,
  output logic [2*DATA_W+LOG2_N-1:0]   peak_value,
  output logic [PHASE_W-1:0]           phase_diff
);

  localparam int ACC_W  = 2*DATA_W + LOG2_N;
  localparam int N      = 1 << LOG2_N;
  localparam int PROD_W = 2*DATA_W;
  localparam logic [LOG2_N-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CORR    = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t state;

  logic signed [DATA_W-1:0] mem_1 [N];
  logic signed [DATA_W-1:0] mem_2 [N];

  logic [LOG2_N-1:0] cnt;
  logic [LOG2_N-1:0] idx_i;
  logic [LOG2_N-1:0] idx_k;
  logic [LOG2_N-1:0] rd_addr_2;
  logic              issuing;

  // Pipeline tags travelling alongside the read and product stages.
  logic              s1_valid;
  logic              s1_last;
  logic [LOG2_N-1:0] s1_k;
  logic              s2_valid;
  logic              s2_last;
  logic [LOG2_N-1:0] s2_k;

  logic signed [DATA_W-1:0] rd_1;
  logic signed [DATA_W-1:0] rd_2;
  logic signed [PROD_W-1:0] prod;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  max_val;
  logic [LOG2_N-1:0]        max_lag;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     take_max;
  logic signed [ACC_W-1:0]  fin_val;
  logic [LOG2_N-1:0]        fin_lag;
  logic [PHASE_W-1:0]       fin_phase;

  // Lag-shifted read address; truncation to LOG2_N bits gives the circular wrap.
  always_comb begin
    rd_addr_2 = idx_i + idx_k;
  end

  // Sample storage; contents survive reset and are simply overwritten next capture.
  always_ff @(posedge clk) begin
    if (state == CAPTURE && sample_valid) begin
      mem_1[cnt] <= signed'(signal_1);
      mem_2[cnt] <= signed'(signal_2);
    end
  end

  // Registered memory read followed by a registered full-width product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_1 <= '0;
      rd_2 <= '0;
      prod <= '0;
    end else begin
      rd_1 <= mem_1[idx_i];
      rd_2 <= mem_2[rd_addr_2];
      prod <= rd_1 * rd_2;
    end
  end

  // Accumulate and running-maximum decision; k=0 always loads, later lags need strictly greater.
  always_comb begin
    prod_ext  = {{LOG2_N{prod[PROD_W-1]}}, prod};
    acc_sum   = acc + prod_ext;
    take_max  = (s2_k == '0) || (acc_sum > max_val);
    fin_val   = take_max ? acc_sum : max_val;
    fin_lag   = take_max ? s2_k : max_lag;
    // peak_lag read as a signed LOG2_N value is exactly the wrapped lag; zero-fill scales it.
    fin_phase = {fin_lag, {(PHASE_W-LOG2_N){1'b0}}};
  end

  // Measurement sequencer: capture, lag/index sweep, pipeline drain and result registration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_lag   <= '0;
      peak_value <= '0;
      phase_diff <= '0;
      cnt        <= '0;
      idx_i      <= '0;
      idx_k      <= '0;
      issuing    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_k       <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_k       <= '0;
      acc        <= '0;
      max_val    <= '0;
      max_lag    <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= (state == CORR) && issuing;
      s1_last  <= (idx_i == LAST_IDX);
      s1_k     <= idx_k;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_k     <= s1_k;

      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        CAPTURE: begin
          if (sample_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state   <= CORR;
              issuing <= 1'b1;
              idx_i   <= '0;
              idx_k   <= '0;
              acc     <= '0;
            end
          end
        end

        CORR: begin
          if (issuing) begin
            idx_i <= idx_i + 1'b1;
            if (idx_i == LAST_IDX) begin
              idx_k <= idx_k + 1'b1;
              if (idx_k == LAST_IDX) begin
                issuing <= 1'b0;
              end
            end
          end
          if (s2_valid) begin
            if (s2_last) begin
              acc     <= '0;
              max_val <= fin_val;
              max_lag <= fin_lag;
              if (s2_k == LAST_IDX) begin
                peak_value <= fin_val;
                peak_lag   <= fin_lag;
                phase_diff <= fin_phase;
                done       <= 1'b1;
                busy       <= 1'b0;
                state      <= RESULT;
              end
            end else begin
              acc <= acc_sum;
            end
          end
        end

        RESULT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_xcorr_engine.sv
// Testbench for phase_xcorr_engine with a 16-point record. Expected results come
// from a direct O(N^2) evaluation of the circular cross-correlation.

module tb_phase_xcorr_engine;

  localparam int DATA_W  = 12;
  localparam int LOG2_N  = 4;
  localparam int PHASE_W = 16;
  localparam int N       = 1 << LOG2_N;
  localparam int ACC_W   = 2*DATA_W + LOG2_N;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                sample_valid = 1'b0;
  logic [DATA_W-1:0]   signal_1 = '0;
  logic [DATA_W-1:0]   signal_2 = '0;
  logic                busy;
  logic                done;
  logic [LOG2_N-1:0]   peak_lag;
  logic [ACC_W-1:0]    peak_value;
  logic [PHASE_W-1:0]  phase_diff;

  int n_tests = 0;
  int n_fail  = 0;

  int pat [N] = '{5, -3, 7, 1, 0, -8, 2, 4, -1, 6, 3, -5, 9, -2, 0, 1};
  int s1  [N];
  int s2  [N];

  phase_xcorr_engine #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N),
    .PHASE_W(PHASE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sample_valid(sample_valid),
    .signal_1    (signal_1),
    .signal_2    (signal_2),
    .busy        (busy),
    .done        (done),
    .peak_lag    (peak_lag),
    .peak_value  (peak_value),
    .phase_diff  (phase_diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: evaluate every R[k] directly, keep the first maximum.
  task automatic model(output int lag, output longint val, output longint ph);
    longint r;
    int     lag_s;
    lag = 0;
    val = 0;
    for (int k = 0; k < N; k++) begin
      r = 0;
      for (int i = 0; i < N; i++) r += longint'(s1[i]) * longint'(s2[(i + k) % N]);
      if (k == 0 || r > val) begin
        val = r;
        lag = k;
      end
    end
    lag_s = (lag < N/2) ? lag : lag - N;
    ph = longint'(lag_s) * (longint'(1) <<< (PHASE_W - LOG2_N));
  endtask

  task automatic set_delay(input int d);
    for (int j = 0; j < N; j++) begin
      s1[j] = pat[j];
      s2[j] = pat[(j - d + N) % N];
    end
  endtask

  task automatic set_const(input int a, input int b);
    for (int j = 0; j < N; j++) begin
      s1[j] = a;
      s2[j] = b;
    end
  endtask

  task automatic set_random(input int d, input int noise);
    for (int j = 0; j < N; j++) s1[j] = int'($urandom_range(4095)) - 2048;
    for (int j = 0; j < N; j++) begin
      s2[j] = s1[(j - d + N) % N] + int'($urandom_range(2*noise)) - noise;
      if (s2[j] > 2047)  s2[j] = 2047;
      if (s2[j] < -2048) s2[j] = -2048;
    end
  endtask

  task automatic feed_samples(input bit toggle);
    for (int j = 0; j < N; j++) begin
      if (toggle && (j % 2 == 1)) begin
        sample_valid = 1'b0;
        signal_1 = DATA_W'($urandom);
        signal_2 = DATA_W'($urandom);
        @(posedge clk); #1;
      end
      sample_valid = 1'b1;
      signal_1 = DATA_W'(s1[j]);
      signal_2 = DATA_W'(s2[j]);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  // Called 1 ns after a rising edge; runs one complete measurement and checks it.
  task automatic run_meas(input string name, input bit toggle, input bit poke_start);
    int     lag_e;
    longint val_e;
    longint ph_e;
    int     cyc;
    int     extra_done;
    model(lag_e, val_e, ph_e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_capture"}, busy, 1);
    feed_samples(toggle);
    cyc = 1;
    while (!done && cyc < 2000) begin
      start = poke_start && (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({name, "_latency"}, cyc, N*N + 3);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_peak_lag"}, peak_lag, lag_e);
    chk({name, "_peak_value"}, longint'($signed(peak_value)), val_e);
    chk({name, "_phase_diff"}, longint'($signed(phase_diff)), ph_e);
    extra_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    chk({name, "_single_done"}, extra_done, 0);
    chk({name, "_lag_hold"}, peak_lag, lag_e);
    chk({name, "_phase_hold"}, longint'($signed(phase_diff)), ph_e);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lag", peak_lag, 0);
    chk("rst_value", peak_value, 0);
    chk("rst_phase", phase_diff, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    set_delay(3);       run_meas("delay3", 1'b0, 1'b0);
    set_delay(14);      run_meas("delay14", 1'b0, 1'b0);
    set_const(100, -100); run_meas("neg_const", 1'b0, 1'b0);
    set_delay(8);       run_meas("delay8", 1'b0, 1'b0);
    set_const(-2048, -2048); run_meas("full_scale", 1'b0, 1'b0);
    set_delay(3);       run_meas("toggle_poke", 1'b1, 1'b1);

    // Abort mid-CORR: outputs from the previous run must clear at once.
    set_delay(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed_samples(1'b0);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lag", peak_lag, 0);
    chk("abort_value", peak_value, 0);
    chk("abort_phase", phase_diff, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    set_delay(3);       run_meas("after_abort", 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      set_random(int'($urandom_range(N - 1)), (t == 3) ? 2047 : 40);
      run_meas($sformatf("rand%0d", t), t[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_xcorr_engine.md
Name: phase_xcorr_engine

Overview:
- Parametrised circular cross-correlation phase detector for the phase_2 measurement path.
- Captures N sample pairs (voltage/current) under a start/valid handshake, then evaluates the full circular cross-correlation R[k] for every lag k = 0..N-1, one MAC per cycle.
- Reports the peak lag, the peak value and a signed phase difference with a done pulse.
- Replaces the single-product-per-lag estimator with a true accumulated correlation; supports configurable data width, record depth and phase width.

Parameters:
- DATA_W, 12, signed sample width of signal_1/signal_2
- LOG2_N, 10, log2 of record length; N = 2^LOG2_N
- PHASE_W, 16, width of phase_diff; must satisfy PHASE_W >= LOG2_N+1
- ACC_W, 2*DATA_W+LOG2_N, accumulator/peak width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a new measurement (honoured in IDLE only)
- sample_valid  in  1  qualifies signal_1/signal_2 during capture
- signal_1  in  DATA_W  signed voltage sample
- signal_2  in  DATA_W  signed current sample
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; results valid from this cycle on
- peak_lag  out  LOG2_N  lag k of maximum R[k]
- peak_value  out  ACC_W  signed maximum R[k]
- phase_diff  out  PHASE_W  signed phase; full scale ±2^(PHASE_W-1) = ±180°

Behaviour:
- Reset (async, rst=0): state IDLE; busy=0, done=0, peak_lag=0, peak_value=0, phase_diff=0; capture/lag/index counters=0. Sample memories are not cleared.
- Definition: R[k] = sum over i=0..N-1 of signal_1[i]*signal_2[(i+k) mod N]. The index wraps by truncation to LOG2_N bits.
  - Products are full 2*DATA_W signed; the accumulator is ACC_W signed and cannot overflow.
- FSM states: IDLE -> CAPTURE -> CORR -> RESULT -> IDLE.
- IDLE: start=1 -> CAPTURE next cycle, busy=1. Any other input is ignored.
- CAPTURE: each cycle with sample_valid=1 stores the pair at index cnt, cnt++. sample_valid=0 stalls the capture with no state change.
  - On acceptance of sample N-1 -> CORR next cycle.
- CORR: nested loop, k outer 0..N-1, i inner 0..N-1, one product issued per cycle. Internal pipeline: registered memory read, registered product, accumulate.
  - When lag k completes, compare against the running maximum.
  - The k=0 result loads the maximum unconditionally (so all-negative records work).
  - For k>0, the maximum updates only on strictly greater. Ties keep the smallest k.
- RESULT: a single cycle that registers the outputs, with done=1 and busy=0 in this cycle; IDLE next cycle.
- Latency: done asserts exactly N*N+3 cycles after the cycle accepting sample N-1. This latency is fixed, independent of data.
- Phase mapping:
  - lag_s = peak_lag if peak_lag < N/2, else peak_lag - N (signed, range -N/2..N/2-1).
  - phase_diff = lag_s << (PHASE_W-1-(LOG2_N-1)), i.e. lag_s * 2^(PHASE_W-LOG2_N).
  - Positive means signal_2 lags signal_1. peak_lag = N/2 gives phase_diff = -2^(PHASE_W-1) (-180°).
- Outputs peak_lag, peak_value and phase_diff hold their values until the next RESULT. done is high for exactly one cycle.
- start while busy is ignored; it is neither queued nor restarts the measurement.
- start in the same cycle as done is ignored (FSM not yet in IDLE).
- Reset mid-CAPTURE/CORR aborts the measurement: all outputs return to reset values, with no done pulse.

Test Plan:
- LOG2_N=4, PHASE_W=16; signal_1 = nonperiodic pattern {5,-3,7,1,0,-8,2,4,-1,6,3,-5,9,-2,0,1}; signal_2 = signal_1 circularly delayed 3 -> peak_lag=3, phase_diff=12288, done N*N+3=259 cycles after the last sample.
- Same pattern, delay 14 (signal_2 leads by 2) -> peak_lag=14, phase_diff=-8192.
- signal_1=+100, signal_2=-100 constant -> all R[k]=-160000; peak_lag=0 (tie rule and unconditional k=0 load), peak_value=-160000, phase_diff=0.
- Delay 8 (N/2) with the pattern -> peak_lag=8, phase_diff=-32768. Full-scale test: signal_1=signal_2=-2048 constant -> peak_value=67108864 with no overflow.
- sample_valid toggled 1/0 during capture and start pulsed during CORR -> exactly 16 samples stored; the extra start is ignored; a single done; results identical to the first scenario.
- rst asserted mid-CORR -> busy=0, all outputs 0 immediately; a new start then yields a correct result.
